// File: rtl/pwr_seq.sv
// pwr_seq: multi-channel rail power sequencer with settle/drain timing on io tri-state.
// Define PWR_SEQ_STAGGER_EN to allow only one channel in RAMP at a time (lowest index first).
module pwr_seq #(
  parameter int CHANNELS    = 2,
  parameter int ON_CYCLES   = 5000,
  parameter int OFF_CYCLES  = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  output logic [CHANNELS-1:0] pwr_ena,
  output logic [CHANNELS-1:0] io_tri,
  output logic [CHANNELS-1:0] ready,
  output logic                busy
);
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  typedef enum logic [1:0] {S_OFF, S_RAMP, S_ON, S_DRAIN} state_t;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0] w_req_s, w_cand, w_grant, w_bz;
  logic r_busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], req};
  assign w_req_s = r_sync[SYNC_STAGES-1];
`ifdef PWR_SEQ_STAGGER_EN
  logic [CHANNELS-1:0] w_in_ramp;
  // isolate the lowest requesting channel, and only while nobody is ramping
  assign w_grant = (|w_in_ramp) ? '0 : (w_cand & (~w_cand + CHANNELS'(1)));
`else
  assign w_grant = w_cand;
`endif
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t r_state, w_next;
    logic [CW-1:0] r_ctr, w_ctr;
    logic r_pwr, r_tri;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_state <= S_OFF;
        r_ctr   <= '0;
        r_pwr   <= 1'b0;
        r_tri   <= 1'b1;
      end else begin
        r_state <= w_next;
        r_ctr   <= w_ctr;
        r_pwr   <= w_next != S_OFF;
        r_tri   <= w_next != S_ON;
      end
    always_comb begin
      w_next = r_state;
      w_ctr  = r_ctr;
      case (r_state)
        S_OFF:
          if (w_grant[g]) begin
            w_next = S_RAMP;
            w_ctr  = CW'(ON_CYCLES);
          end
        S_RAMP:
          if (!w_req_s[g]) w_next = S_OFF;
          else if (r_ctr == CW'(1)) w_next = S_ON;
          else w_ctr = r_ctr - CW'(1);
        S_ON:
          if (!w_req_s[g]) begin
            w_next = S_DRAIN;
            w_ctr  = CW'(OFF_CYCLES);
          end
        default:
          if (r_ctr == CW'(1)) w_next = S_OFF;
          else w_ctr = r_ctr - CW'(1);
      endcase
    end
    assign w_cand[g]  = (r_state == S_OFF) && w_req_s[g];
    assign w_bz[g]    = (w_next == S_RAMP) || (w_next == S_DRAIN);
    assign pwr_ena[g] = r_pwr;
    assign io_tri[g]  = r_tri;
    assign ready[g]   = ~r_tri;
`ifdef PWR_SEQ_STAGGER_EN
    assign w_in_ramp[g] = r_state == S_RAMP;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_busy <= 1'b0;
    else r_busy <= |w_bz;
  assign busy = r_busy;
endmodule

// File: tb/tb_pwr_seq.sv
// tb_pwr_seq: directed self-checking bench for pwr_seq (2 channels, ON=8, OFF=4, 2 sync stages).
module tb_pwr_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] pwr_ena, io_tri, ready;
  logic busy;
  logic [6:0] obs;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  pwr_seq #(.CHANNELS(2), .ON_CYCLES(8), .OFF_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .pwr_ena(pwr_ena), .io_tri(io_tri), .ready(ready), .busy(busy)
  );
  assign obs = {pwr_ena, io_tri, ready, busy};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [6:0] e;
    e = 7'b00_11_00_0;
    #1 rst = 1'b1;
    req = 2'b00;
    #1;
    checks++;
    if (obs !== e) $display("FAIL reset_hold got=%b exp=%b", obs, e);
    else passed++;
    tick;
    tick;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      checks++;
      if (obs !== e) $display("FAIL idle k=%0d got=%b exp=%b", k, obs, e);
      else passed++;
    end
  endtask
  task automatic test_ramp;
    logic [6:0] e;
    req = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      tick;
      e = {1'b0, k >= 3, 1'b1, k < 11, 1'b0, k >= 11, (k >= 3 && k <= 10)};
      checks++;
      if (obs !== e) $display("FAIL ramp k=%0d got=%b exp=%b", k, obs, e);
      else passed++;
    end
  endtask
  task automatic test_drain;
    logic [6:0] e;
    req = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick;
      e = {1'b0, k != 7, 1'b1, k >= 3, 1'b0, k < 3, ((k >= 3 && k <= 6) || k >= 8)};
      checks++;
      if (obs !== e) $display("FAIL drain k=%0d got=%b exp=%b", k, obs, e);
      else passed++;
      if (k == 4) req = 2'b01;
    end
    req = 2'b00;
    for (int k = 0; k < 6; k++) tick;
    e = 7'b00_11_00_0;
    checks++;
    if (obs !== e) $display("FAIL drain_abort got=%b exp=%b", obs, e);
    else passed++;
  endtask
  task automatic test_pulse;
    logic [6:0] e;
    req = 2'b10;
    for (int k = 1; k <= 9; k++) begin
      tick;
      e = {(k >= 3 && k <= 6), 1'b0, 2'b11, 2'b00, (k >= 3 && k <= 6)};
      checks++;
      if (obs !== e) $display("FAIL pulse k=%0d got=%b exp=%b", k, obs, e);
      else passed++;
      if (k == 4) req = 2'b00;
    end
  endtask
  task automatic test_reset_mid;
    logic [6:0] e;
    req = 2'b01;
    for (int k = 0; k < 8; k++) tick;
    e = 7'b01_11_00_1;
    checks++;
    if (obs !== e) $display("FAIL mid_ramp got=%b exp=%b", obs, e);
    else passed++;
    #1 rst = 1'b1;
    #1;
    e = 7'b00_11_00_0;
    checks++;
    if (obs !== e) $display("FAIL async_reset got=%b exp=%b", obs, e);
    else passed++;
    tick;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      e = {1'b0, k >= 3, 1'b1, k < 11, 1'b0, k >= 11, (k >= 3 && k <= 10)};
      checks++;
      if (obs !== e) $display("FAIL post_reset k=%0d got=%b exp=%b", k, obs, e);
      else passed++;
    end
    req = 2'b00;
    for (int k = 0; k < 10; k++) tick;
  endtask
  task automatic test_stagger;
    logic [6:0] e;
    logic p1, t1, b;
    req = 2'b11;
    for (int k = 1; k <= 21; k++) begin
      tick;
`ifdef PWR_SEQ_STAGGER_EN
      p1 = k >= 12;
      t1 = k < 20;
      b  = (k >= 3 && k <= 10) || (k >= 12 && k <= 19);
`else
      p1 = k >= 3;
      t1 = k < 11;
      b  = k >= 3 && k <= 10;
`endif
      e = {p1, k >= 3, t1, k < 11, ~t1, k >= 11, b};
      checks++;
      if (obs !== e) $display("FAIL both k=%0d got=%b exp=%b", k, obs, e);
      else passed++;
    end
    req = 2'b00;
    for (int k = 0; k < 10; k++) tick;
  endtask
  initial begin
    test_reset;
    test_ramp;
    test_drain;
    test_pulse;
    test_reset_mid;
    test_stagger;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
